// File: rtl/clk_div_multi_if.sv
// Control and clock-output bundle for the multi-channel clock divider.
// The master drives ratio/enable per channel; the slave (divider) returns clocks and strobes.
interface clk_div_multi_if #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned RATIO_W = 8
);
    logic [N_CH-1:0]         i_clk_en;
    logic [N_CH*RATIO_W-1:0] divided_ratio;
    logic [N_CH-1:0]         div_clk_out;
    logic [N_CH-1:0]         o_tick;
    logic [N_CH-1:0]         o_ratio_upd;

    modport master (
        output i_clk_en,
        output divided_ratio,
        input  div_clk_out,
        input  o_tick,
        input  o_ratio_upd
    );

    modport slave (
        input  i_clk_en,
        input  divided_ratio,
        output div_clk_out,
        output o_tick,
        output o_ratio_upd
    );
endinterface

// File: rtl/clk_div_multi.sv
// N_CH independent integer clock dividers; ratio/enable changes are shadowed and
// only take effect at a divided-period boundary so no runt phases are produced.
module clk_div_multi #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned RATIO_W = 8
) (
    input  logic             clk,
    input  logic             rest,
    clk_div_multi_if.slave   bus
);

    logic [RATIO_W-1:0] r_ratio [N_CH];
    logic [RATIO_W-1:0] r_cnt   [N_CH];
    logic [N_CH-1:0]    r_en;
    logic [N_CH-1:0]    r_div_q;
    logic [N_CH-1:0]    r_tick;
    logic [N_CH-1:0]    r_upd;

    logic [RATIO_W-1:0] w_in_ratio [N_CH];
    logic [RATIO_W-1:0] w_ratio_n  [N_CH];
    logic [RATIO_W-1:0] w_cnt_n    [N_CH];
    logic [N_CH-1:0]    w_en_n;
    logic [N_CH-1:0]    w_active;
    logic [N_CH-1:0]    w_active_n;
    logic [N_CH-1:0]    w_end;
    logic [N_CH-1:0]    w_div_n;
    logic [N_CH-1:0]    w_tick_n;
    logic [N_CH-1:0]    w_upd_n;

    // Next-state per channel; div_q and tick are registered from the next-state view
    // so they line up with the counter value of the same cycle.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_in_ratio[k] = bus.divided_ratio[k*RATIO_W +: RATIO_W];
            w_active[k]   = r_en[k] && (r_ratio[k] >= RATIO_W'(2));
            w_end[k]      = w_active[k] && (r_cnt[k] == r_ratio[k] - RATIO_W'(1));
            w_ratio_n[k]  = r_ratio[k];
            w_en_n[k]     = r_en[k];
            w_cnt_n[k]    = r_cnt[k] + RATIO_W'(1);
            w_upd_n[k]    = 1'b0;

            if (!w_active[k] || w_end[k]) begin
                w_ratio_n[k] = w_in_ratio[k];
                w_en_n[k]    = bus.i_clk_en[k];
                w_cnt_n[k]   = '0;
                w_upd_n[k]   = w_end[k] &&
                               ((w_in_ratio[k] != r_ratio[k]) || (bus.i_clk_en[k] != r_en[k]));
            end

            w_active_n[k] = w_en_n[k] && (w_ratio_n[k] >= RATIO_W'(2));
            w_div_n[k]    = w_active_n[k] && (w_cnt_n[k] >= (w_ratio_n[k] >> 1));
            w_tick_n[k]   = w_active_n[k] && (w_cnt_n[k] == w_ratio_n[k] - RATIO_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            for (int k = 0; k < N_CH; k++) begin
                r_ratio[k] <= '0;
                r_cnt[k]   <= '0;
            end
            r_en    <= '0;
            r_div_q <= '0;
            r_tick  <= '0;
            r_upd   <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                r_ratio[k] <= w_ratio_n[k];
                r_cnt[k]   <= w_cnt_n[k];
            end
            r_en    <= w_en_n;
            r_div_q <= w_div_n;
            r_tick  <= w_tick_n;
            r_upd   <= w_upd_n;
        end
    end

    // Bypass channels pass the source clock straight through.
    assign bus.div_clk_out = (w_active & r_div_q) | (~w_active & {N_CH{clk}});
    assign bus.o_tick      = r_tick;
    assign bus.o_ratio_upd = r_upd;

endmodule
